// File: rtl/combi_alu_arbiter.sv
// Two-requester round-robin front end for one shared 8-bit add/sub/mul/div unit.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP hands the result back.
module combi_alu_arbiter #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] DIV0_RESULT = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [1:0]        i_req0_op,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [1:0]        i_req1_op,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_div0,
    output logic              o_busy
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_div0_q, rsp_div0_d;
    logic              gnt0, gnt1;

    function automatic logic [DATA_W-1:0] alu_result(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   res;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = prod[DATA_W-1:0];
            default: res = (b == '0) ? DIV0_RESULT : a / b;
        endcase
        return res;
    endfunction

    function automatic logic alu_div0(input logic [1:0] op, input logic [DATA_W-1:0] b);
        return (op == OP_DIV) && (b == '0);
    endfunction

    // A lone valid always wins; on a tie the priority pointer decides.
    assign gnt0 = i_req0_valid & (~i_req1_valid | ~ptr_q);
    assign gnt1 = i_req1_valid & (~i_req0_valid |  ptr_q);

    assign o_req0_ready = i_rst_n & (state_q == ST_IDLE) & gnt0;
    assign o_req1_ready = i_rst_n & (state_q == ST_IDLE) & gnt1;

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_div0  = rsp_div0_q;
    assign o_busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_div0_d  = rsp_div0_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0) begin
                    op_d    = i_req0_op;
                    a_d     = i_req0_a;
                    b_d     = i_req0_b;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
                end else if (gnt1) begin
                    op_d    = i_req1_op;
                    a_d     = i_req1_a;
                    b_d     = i_req1_b;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_result(op_q, a_q, b_q);
                rsp_div0_d  = alu_div0(op_q, b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // The pointer only advances once the consumer has actually taken the result.
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_div0_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_div0_q  <= rsp_div0_d;
        end
    end

    // Operand latches are only read in EXEC after being loaded in IDLE, so they need no reset.
    always_ff @(posedge i_clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
        id_q <= id_d;
    end

endmodule

// File: tb/tb_combi_alu_arbiter.sv
// Bench for combi_alu_arbiter: transaction-level scoreboard checked every cycle plus directed scenarios.
module tb_combi_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, r0, r1;
    logic [1:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_div0, busy;
    logic [7:0] rsp_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    combi_alu_arbiter #(.DATA_W(8), .DIV0_RESULT(8'hFF)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_data(rsp_data), .o_rsp_div0(rsp_div0), .o_busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic, straight from the operation definitions.
    function automatic int ref_data(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            default: return (b == 0) ? 255 : a / b;
        endcase
    endfunction

    // Scoreboard: at most one accepted operation outstanding, result due two cycles after acceptance.
    bit m_busy = 0;
    bit m_ptr  = 0;
    int m_acc, m_id, m_data, m_div0;
    int grants[$];

    always @(negedge clk) begin
        bit e0, e1, ev;
        if (!rst_n) begin
            m_busy = 0;
            m_ptr  = 0;
            chk("rst_ready0", r0, 0);
            chk("rst_ready1", r1, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_div0", rsp_div0, 0);
            chk("rst_busy", busy, 0);
        end else begin
            e0 = !m_busy && v0 && (!v1 || !m_ptr);
            e1 = !m_busy && v1 && (!v0 ||  m_ptr);
            ev = m_busy && (cyc >= m_acc + 2);
            chk("ready0", r0, e0);
            chk("ready1", r1, e1);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_div0", rsp_div0, m_div0);
            end
            if (e0 || e1) begin
                m_busy = 1;
                m_acc  = cyc;
                m_id   = e1;
                m_data = e1 ? ref_data(op1, a1, b1) : ref_data(op0, a0, b0);
                m_div0 = e1 ? (op1 == 3 && b1 == 0) : (op0 == 3 && b0 == 0);
                grants.push_back(m_id);
            end else if (ev && rsp_ready) begin
                m_busy = 0;
                m_ptr  = !m_id;
            end
        end
    end

    task automatic wait_ready(input int id, output int rc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? r1 : r0) && n < 50);
        if (n >= 50) chk("ready_timeout", 1, 0);
        rc = cyc;
    endtask

    task automatic wait_rsp(output int vc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        if (n >= 50) chk("rsp_timeout", 1, 0);
        vc = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input int id, input int op, input int a, input int b,
                         output int data, output int div0, output int rid);
        int rc, vc;
        @(posedge clk); #1;
        if (id == 0) begin v0 = 1; op0 = op[1:0]; a0 = a[7:0]; b0 = b[7:0]; end
        else         begin v1 = 1; op1 = op[1:0]; a1 = a[7:0]; b1 = b[7:0]; end
        wait_ready(id, rc);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        wait_rsp(vc);
        chk("latency", vc - rc, 2);
        data = rsp_data;
        div0 = rsp_div0;
        rid  = rsp_id;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    int d, z, id, rc, vc, rel;
    logic [7:0] held;

    initial begin
        rst_n = 0; rsp_ready = 1;
        v0 = 1; v1 = 1; op0 = 0; op1 = 0; a0 = 8'd1; b0 = 8'd1; a1 = 8'd2; b1 = 8'd2;
        repeat (3) @(posedge clk);
        #1 v0 = 0; v1 = 0; rst_n = 1;

        // 1: wrapping add
        do_op(0, 0, 200, 100, d, z, id);
        chk("t1_data", d, 44); chk("t1_div0", z, 0); chk("t1_id", id, 0);

        // 2: wrapping sub, truncated mul
        do_op(1, 1, 5, 10, d, z, id);
        chk("t2_sub", d, 8'hFB); chk("t2_id", id, 1);
        do_op(1, 2, 20, 20, d, z, id);
        chk("t2_mul", d, 8'h90);

        // 3: divide and divide by zero
        do_op(0, 3, 100, 7, d, z, id);
        chk("t3_div", d, 14); chk("t3_div_flag", z, 0);
        do_op(1, 3, 9, 0, d, z, id);
        chk("t3_div0_data", d, 8'hFF); chk("t3_div0_flag", z, 1);

        // 4: both held from reset -> strict alternation
        pulse_reset();
        grants.delete();
        @(posedge clk); #1;
        v0 = 1; op0 = 0; a0 = 8'd1; b0 = 8'd1;
        v1 = 1; op1 = 0; a1 = 8'd2; b1 = 8'd2;
        for (int n = 0; n < 100 && grants.size() < 4; n++) @(negedge clk);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        chk("t4_ngrants", grants.size(), 4);
        if (grants.size() >= 4) begin
            chk("t4_g0", grants[0], 0); chk("t4_g1", grants[1], 1);
            chk("t4_g2", grants[2], 0); chk("t4_g3", grants[3], 1);
        end
        wait_idle();

        // 5: consumer stalls 5 cycles while req1 waits
        rsp_ready = 0;
        @(posedge clk); #1;
        v0 = 1; op0 = 0; a0 = 8'd3; b0 = 8'd4;
        wait_ready(0, rc);
        @(posedge clk); #1;
        v0 = 0; v1 = 1; op1 = 1; a1 = 8'd9; b1 = 8'd2;
        wait_rsp(vc);
        held = rsp_data;
        chk("t5_data", held, 7);
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_data", rsp_data, held);
            chk("t5_no_ready1", r1, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        rel = cyc;
        wait_ready(1, rc);
        chk("t5_accept_after_release", rc > rel, 1);
        @(posedge clk); #1;
        v1 = 0;
        wait_rsp(vc);
        chk("t5_second", rsp_data, 7);
        wait_idle();

        // 6: reset mid-RESP abandons the result and restores req0 priority
        do_op(0, 0, 1, 2, d, z, id);
        @(posedge clk); #1;
        v0 = 1; op0 = 0; a0 = 8'd10; b0 = 8'd20;
        wait_ready(0, rc);
        @(posedge clk); #1;
        v0 = 0;
        wait_rsp(vc);
        chk("t6_pre_data", rsp_data, 30);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("t6_async_valid", rsp_valid, 0);
        chk("t6_async_data", rsp_data, 0);
        chk("t6_async_busy", busy, 0);
        v0 = 1; v1 = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        grants.delete();
        for (int n = 0; n < 20 && grants.size() < 1; n++) @(negedge clk);
        chk("t6_ngrants", grants.size(), 1);
        if (grants.size() >= 1) chk("t6_first_grant", grants[0], 0);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
